// File: rtl/led_pattern_ctrl_pkg.sv
// Shared encodings and constants for the LED pattern controller.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [7:0] PAT_OFF          = 8'h00;
    localparam logic [7:0] PAT_BLINK_START  = 8'hFF;
    localparam logic [7:0] PAT_ONEHOT_START = 8'h01;

    // Switch bit positions
    localparam int unsigned SW_MODE_LSB = 0;
    localparam int unsigned SW_MODE_MSB = 1;
    localparam int unsigned SW_SPD_LSB  = 2;
    localparam int unsigned SW_SPD_MSB  = 3;
    localparam int unsigned SW_INV      = 4;
    localparam int unsigned SW_PAUSE    = 5;

    // Pattern loaded when a mode is entered
    function automatic logic [7:0] mode_start(input mode_t m);
        case (m)
            MODE_BLINK:  return PAT_BLINK_START;
            MODE_CHASE:  return PAT_ONEHOT_START;
            MODE_BOUNCE: return PAT_ONEHOT_START;
            default:     return PAT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Tick scheduler: down-counter that pulses once per 2^(BASE_LOG2 - spd) cycles.
module led_tick_gen #(
    parameter int unsigned BASE_LOG2 = 25,
    parameter int unsigned CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_spd,
    output logic       o_tick
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RESET = (ONE << BASE_LOG2) - ONE;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [CNT_W-1:0] w_reload;

    // Reload value sampled from the current speed only when the counter expires
    assign w_reload = (ONE << (BASE_LOG2 - 32'(i_spd))) - ONE;

    // Count down; pulse and reload on zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= CNT_RESET;
            r_tick <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt  <= w_reload;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt - ONE;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: switch synchroniser, mode/pattern state machine, output register.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned BASE_LOG2 = 25,
    parameter int unsigned CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    output logic [7:0] LED,
    output logic       tick
);

    logic [7:0] r_sw_meta;
    logic [7:0] r_sw_s;
    mode_t      r_mode;
    dir_t       r_dir;
    logic [7:0] r_pat;
    logic [7:0] r_led;
    logic       w_tick;
    mode_t      w_sw_mode;
    logic       w_unused_rsvd;

    assign w_sw_mode     = mode_t'(r_sw_s[SW_MODE_MSB:SW_MODE_LSB]);
    assign w_unused_rsvd = ^r_sw_s[7:6];

    // Two-flop synchroniser for the switch bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_s    <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_s    <= r_sw_meta;
        end
    end

    led_tick_gen #(
        .BASE_LOG2 (BASE_LOG2),
        .CNT_W     (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_spd  (r_sw_s[SW_SPD_MSB:SW_SPD_LSB]),
        .o_tick (w_tick)
    );

    // Pattern state machine: on each tick either enter a new mode or advance the pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_OFF;
            r_dir  <= DIR_LEFT;
            r_pat  <= PAT_OFF;
        end else if (w_tick) begin
            if (w_sw_mode != r_mode) begin
                r_mode <= w_sw_mode;
                r_dir  <= DIR_LEFT;
                r_pat  <= mode_start(w_sw_mode);
            end else if (!r_sw_s[SW_PAUSE]) begin
                case (r_mode)
                    MODE_OFF:   r_pat <= PAT_OFF;
                    MODE_BLINK: r_pat <= ~r_pat;
                    MODE_CHASE: r_pat <= {r_pat[6:0], r_pat[7]};
                    MODE_BOUNCE: begin
                        // Flip direction as the end value is loaded so it shows for one step only
                        if (r_dir == DIR_LEFT) begin
                            r_pat <= r_pat << 1;
                            if (r_pat == 8'h40) r_dir <= DIR_RIGHT;
                        end else begin
                            r_pat <= r_pat >> 1;
                            if (r_pat == 8'h02) r_dir <= DIR_LEFT;
                        end
                    end
                    default:    r_pat <= PAT_OFF;
                endcase
            end
        end
    end

    // Output register with optional inversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= r_pat ^ {8{r_sw_s[SW_INV]}};
        end
    end

    assign LED  = r_led;
    assign tick = w_tick;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomised scoreboard bench for led_pattern_ctrl with a step-index reference model.
module tb_led_pattern_ctrl;

    localparam int unsigned B = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'h00;
    logic [7:0] LED;
    logic       tick;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       t;
        logic [7:0] led;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .BASE_LOG2 (B),
        .CNT_W     (5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .LED  (LED),
        .tick (tick)
    );

    // Pattern as a function of mode and number of steps taken since the mode was entered
    function automatic logic [7:0] pat_of(input logic [1:0] md, input int unsigned kk);
        int unsigned i;
        case (md)
            2'd0: return 8'h00;
            2'd1: return (kk % 2 == 0) ? 8'hFF : 8'h00;
            2'd2: return 8'(1 << (kk % 8));
            default: begin
                i = kk % 14;
                return (i <= 7) ? 8'(1 << i) : 8'(1 << (14 - i));
            end
        endcase
    endfunction

    // Reference model state
    int unsigned n, next_tick, k;
    logic [1:0]  m_mode;
    logic [7:0]  m_pat, m_led, d1, ss, ss_prev, pat_prev;
    logic        m_tick, tick_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0; next_tick = 1 << B; k = 0;
            m_mode = 2'd0; m_pat = 8'h00; m_led = 8'h00;
            d1 = 8'h00; ss = 8'h00; m_tick = 1'b0;
            q.delete();
        end else begin
            tick_prev = m_tick;
            ss_prev   = ss;
            pat_prev  = m_pat;
            n++;
            m_tick = (n == next_tick);
            if (m_tick) next_tick = n + (1 << (B - ss_prev[3:2]));
            if (tick_prev) begin
                if (ss_prev[1:0] != m_mode) begin
                    m_mode = ss_prev[1:0];
                    k = 0;
                end else if (!ss_prev[5]) begin
                    k++;
                end
                m_pat = pat_of(m_mode, k);
            end
            m_led = pat_prev ^ {8{ss_prev[4]}};
            ss = d1;
            d1 = sw;
            q.push_back('{t: m_tick, led: m_led});
        end
    end

    // Monitor: compare DUT outputs against the model every cycle away from the edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            total++;
            if (LED !== 8'h00 || tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: LED=%h tick=%b want LED=00 tick=0", LED, tick);
            end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (tick !== e.t) begin
                bad++;
                $display("FAIL tick @%0t: got %b want %b", $time, tick, e.t);
            end
            total++;
            if (LED !== e.led) begin
                bad++;
                $display("FAIL led @%0t: got %h want %h", $time, LED, e.led);
            end
        end
    end

    task automatic cyc(input int unsigned c);
        repeat (c) @(negedge clk);
    endtask

    // Assert reset between edges and check it acts without a clock
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (LED !== 8'h00 || tick !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: LED=%h tick=%b want LED=00 tick=0", LED, tick);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 8'h00;
        cyc(3);
        #2 rst = 1'b0;
        @(negedge clk);
        cyc(40);
        sw = 8'h02; cyc(16 * 10);
        sw = 8'h03; cyc(16 * 17);
        sw = 8'h01; cyc(40);
        sw = 8'h0D; cyc(40);
        sw = 8'h02; cyc(16 * 6);
        sw = 8'h22; cyc(80);
        sw = 8'h32; cyc(10);
        sw = 8'h12; cyc(40);
        sw = 8'h03; cyc(16 * 12);
        sw = 8'h23; cyc(40);
        async_reset();
        cyc(20);
        for (int i = 0; i < 150; i++) begin
            sw = 8'($urandom);
            cyc($urandom_range(1, 40));
            if ($urandom_range(0, 30) == 0) async_reset();
        end
        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
